// File: rtl/scan_llr_pe.sv
// scan_llr_pe: two-stage, back-pressurable min-sum LLR update over LANES
// independent lanes. Each lane computes
//   left  = minsum(L1, sat(L2+B2))
//   right = sat(minsum(L1,B1) + L2)
// The arithmetic is split across two register stages. A valid bit per stage
// provides ready/valid flow control.

// Per-lane datapath: stage-1 operand/partial registers and stage-2 results.
module scan_llr_lane #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld1,
    input  logic             ld2,
    input  logic [WIDTH-1:0] l1,
    input  logic [WIDTH-1:0] l2,
    input  logic [WIDTH-1:0] b1,
    input  logic [WIDTH-1:0] b2,
    output logic [WIDTH-1:0] left,
    output logic [WIDTH-1:0] right
);
    localparam logic [WIDTH-1:0] CEIL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] FLOR = {1'b1, {(WIDTH-1){1'b0}}};

    // Two's-complement add clamped to [FLOR, CEIL]. Overflow shows up as a
    // disagreement between the two top bits of the one-bit-wider sum.
    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH:0] sum;
        sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        if (sum[WIDTH] != sum[WIDTH-1])
            return sum[WIDTH] ? FLOR : CEIL;
        return sum[WIDTH-1:0];
    endfunction

    // Magnitude. |FLOR| is not representable, so it is clamped to CEIL.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        if (!x[WIDTH-1])
            return x;
        return (x == FLOR) ? CEIL : -x;
    endfunction

    // Sign is the XOR of the input signs. A zero magnitude stays zero, because
    // negating zero gives zero.
    function automatic logic [WIDTH-1:0] minsum(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] mx;
        logic [WIDTH-1:0] my;
        logic [WIDTH-1:0] m;
        mx = mag(x);
        my = mag(y);
        m  = (mx < my) ? mx : my;
        return (x[WIDTH-1] ^ y[WIDTH-1]) ? -m : m;
    endfunction

    logic [WIDTH-1:0] s1_l1, s1_l2, s1_sum, s1_ms;

    // Stage 1: capture L1, L2 and the two independent partial results.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_l1  <= '0;
            s1_l2  <= '0;
            s1_sum <= '0;
            s1_ms  <= '0;
        end else if (ld1) begin
            s1_l1  <= l1;
            s1_l2  <= l2;
            s1_sum <= sat_add(l2, b2);
            s1_ms  <= minsum(l1, b1);
        end
    end

    // Stage 2: finish both outputs. The results hold while the stage is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            left  <= '0;
            right <= '0;
        end else if (ld2) begin
            left  <= minsum(s1_l1, s1_sum);
            right <= sat_add(s1_ms, s1_l2);
        end
    end
endmodule

module scan_llr_pe #(
    parameter int WIDTH = 6,
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_l1,
    input  logic [LANES*WIDTH-1:0] in_l2,
    input  logic [LANES*WIDTH-1:0] in_b1,
    input  logic [LANES*WIDTH-1:0] in_b2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_left,
    output logic [LANES*WIDTH-1:0] out_right,
    output logic [15:0]            out_count
);
    localparam int STAGES = 2;

    // vld_pipe[s] marks stage s as full.
    logic [STAGES:1] vld_pipe;
    logic            ld1, ld2, out_fire;

    // Stage 2 takes stage 1's tuple when stage 2 is empty or draining this cycle.
    // in_ready is built from stage state and out_ready only, never in_valid.
    always_comb begin
        ld2      = vld_pipe[1] & (~vld_pipe[2] | out_ready);
        in_ready = ~rst & (~vld_pipe[1] | ld2);
        ld1      = in_valid & in_ready;
        out_fire = vld_pipe[2] & out_ready;
    end

    assign out_valid = vld_pipe[2];

    // Stage occupancy and the delivered-result counter. The counter wraps at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            out_count <= '0;
        end else begin
            vld_pipe[1] <= ld1 | (vld_pipe[1] & ~ld2);
            vld_pipe[2] <= ld2 | (vld_pipe[2] & ~out_ready);
            if (out_fire)
                out_count <= out_count + 16'd1;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        scan_llr_lane #(.WIDTH(WIDTH)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .ld1   (ld1),
            .ld2   (ld2),
            .l1    (in_l1[i*WIDTH +: WIDTH]),
            .l2    (in_l2[i*WIDTH +: WIDTH]),
            .b1    (in_b1[i*WIDTH +: WIDTH]),
            .b2    (in_b2[i*WIDTH +: WIDTH]),
            .left  (out_left[i*WIDTH +: WIDTH]),
            .right (out_right[i*WIDTH +: WIDTH])
        );
    end
endmodule

// File: tb/tb_scan_llr_pe.sv
// Self-checking bench for scan_llr_pe. It applies a directed vector table,
// then hand-written stall and reset sequences, then streamed traffic checked
// against an integer reference model.
module tb_scan_llr_pe;
    localparam int W      = 6;
    localparam int LANES  = 4;
    localparam int LW     = W * LANES;
    localparam int CEIL_I = (1 << (W - 1)) - 1;
    localparam int FLOR_I = -(1 << (W - 1));

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [LW-1:0] in_l1, in_l2, in_b1, in_b2, out_left, out_right;
    logic [15:0]   out_count;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;

    scan_llr_pe #(.WIDTH(W), .LANES(LANES)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_l1(in_l1), .in_l2(in_l2), .in_b1(in_b1), .in_b2(in_b2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_left(out_left), .out_right(out_right), .out_count(out_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge. Checks run 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model over plain integers.
    function automatic int clampi(input int v);
        if (v > CEIL_I) return CEIL_I;
        if (v < FLOR_I) return FLOR_I;
        return v;
    endfunction

    function automatic int msi(input int x, input int y);
        int ax, ay, m;
        ax = (x < 0) ? -x : x;
        ay = (y < 0) ? -y : y;
        if (ax > CEIL_I) ax = CEIL_I;
        if (ay > CEIL_I) ay = CEIL_I;
        m = (ax < ay) ? ax : ay;
        return ((x < 0) != (y < 0)) ? -m : m;
    endfunction

    task automatic model(input logic [LW-1:0] l1v, l2v, b1v, b2v,
                         output logic [LW-1:0] lo, output logic [LW-1:0] ro);
        for (int i = 0; i < LANES; i++) begin
            int a, b, c, d, lf, rt;
            a  = int'($signed(l1v[i*W +: W]));
            b  = int'($signed(l2v[i*W +: W]));
            c  = int'($signed(b1v[i*W +: W]));
            d  = int'($signed(b2v[i*W +: W]));
            lf = msi(a, clampi(b + d));
            rt = clampi(msi(a, c) + b);
            lo[i*W +: W] = W'(lf);
            ro[i*W +: W] = W'(rt);
        end
    endtask

    task automatic rand_in();
        in_l1 = LW'($urandom());
        in_l2 = LW'($urandom());
        in_b1 = LW'($urandom());
        in_b2 = LW'($urandom());
    endtask

    // Streamed traffic checked against a scoreboard. In mode 0, in_valid is
    // held high and out_ready follows 1,0,0,... In mode 1 both are random.
    task automatic run_stream(input int n, input int mode);
        logic [LW-1:0] ql[$];
        logic [LW-1:0] qr[$];
        logic [LW-1:0] el, er, pl, pr;
        int  sent = 0, got = 0, cyc = 0;
        bit  have = 0, prev_stall = 0;
        while (got < n && cyc < n * 20 + 100) begin
            tick();
            if (!have && sent < n) begin
                rand_in();
                have = 1;
            end
            in_valid  = have && (mode == 0 || $urandom_range(0, 3) != 0);
            out_ready = (mode == 0) ? (cyc % 3 == 0) : ($urandom_range(0, 2) != 0);
            #1;
            if (prev_stall) begin
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_left", int'(out_left), int'(pl));
                chk("stall_right", int'(out_right), int'(pr));
            end
            if (out_valid && out_ready) begin
                if (ql.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    el = ql.pop_front();
                    er = qr.pop_front();
                    chk("stream_left", int'(out_left), int'(el));
                    chk("stream_right", int'(out_right), int'(er));
                end
                got++;
            end
            prev_stall = out_valid && !out_ready;
            pl = out_left;
            pr = out_right;
            if (in_valid && in_ready) begin
                model(in_l1, in_l2, in_b1, in_b2, el, er);
                ql.push_back(el);
                qr.push_back(er);
                sent++;
                have = 0;
            end
            cyc++;
        end
        chk("stream_timeout_outputs", got, n);
        exp_cnt += got;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("stream_count", int'(out_count), exp_cnt);
    endtask

    typedef struct {
        int l1, l2, b1, b2, left, right;
    } vec_t;
    vec_t tbl[9];

    initial begin
        logic [LW-1:0] ea, eb, fa, fb;
        int ln;
        tbl[0] = '{10, 5, -3, 4, 9, 2};
        tbl[1] = '{-20, 25, 31, 20, -20, 5};
        tbl[2] = '{20, 31, 20, 0, 20, 31};
        tbl[3] = '{-32, 0, -32, 0, 0, 31};
        tbl[4] = '{-32, -32, -32, -32, 31, -1};
        tbl[5] = '{7, -3, -5, -2, -5, -8};
        tbl[6] = '{0, 10, -9, 3, 0, 10};
        tbl[7] = '{-1, -31, 1, -1, 1, -32};
        tbl[8] = '{31, -20, -31, -20, -31, -32};

        // Reset state.
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_l1 = '0; in_l2 = '0; in_b1 = '0; in_b2 = '0;
        tick(); tick(); tick();
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_left", int'(out_left), 0);
        chk("rst_out_right", int'(out_right), 0);
        chk("rst_out_count", int'(out_count), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);

        // Directed table. The vector goes in one lane, and every other lane
        // carries 1,1,1,1, which gives left=1 and right=2.
        for (int k = 0; k < 9; k++) begin
            ln = k % LANES;
            for (int i = 0; i < LANES; i++) begin
                in_l1[i*W +: W] = W'(1); in_l2[i*W +: W] = W'(1);
                in_b1[i*W +: W] = W'(1); in_b2[i*W +: W] = W'(1);
                ea[i*W +: W] = W'(1);    eb[i*W +: W] = W'(2);
            end
            in_l1[ln*W +: W] = W'(tbl[k].l1);
            in_l2[ln*W +: W] = W'(tbl[k].l2);
            in_b1[ln*W +: W] = W'(tbl[k].b1);
            in_b2[ln*W +: W] = W'(tbl[k].b2);
            ea[ln*W +: W] = W'(tbl[k].left);
            eb[ln*W +: W] = W'(tbl[k].right);
            tick();
            in_valid = 1'b1; out_ready = 1'b1;
            #1;
            chk("dir_in_ready", int'(in_ready), 1);
            tick();
            in_valid = 1'b0;
            #1;
            chk("dir_lat_early", int'(out_valid), 0);
            tick(); #1;
            chk("dir_valid", int'(out_valid), 1);
            chk("dir_left", int'(out_left), int'(ea));
            chk("dir_right", int'(out_right), int'(eb));
            tick(); #1;
            exp_cnt++;
            chk("dir_drained", int'(out_valid), 0);
            chk("dir_count", int'(out_count), exp_cnt);
        end

        // Fill the pipeline with out_ready low, then release it.
        tick();
        rand_in(); in_valid = 1'b1; out_ready = 1'b0;
        model(in_l1, in_l2, in_b1, in_b2, ea, eb);
        #1; chk("full_a_ready", int'(in_ready), 1);
        tick();
        rand_in();
        model(in_l1, in_l2, in_b1, in_b2, fa, fb);
        #1; chk("full_b_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("full_in_ready_low", int'(in_ready), 0);
        chk("full_out_valid", int'(out_valid), 1);
        chk("full_left_a", int'(out_left), int'(ea));
        tick(); #1;
        chk("full_hold_ready", int'(in_ready), 0);
        chk("full_hold_left", int'(out_left), int'(ea));
        chk("full_hold_right", int'(out_right), int'(eb));
        tick();
        out_ready = 1'b1;
        #1;
        chk("full_release_ready", int'(in_ready), 1);
        chk("full_out_a_right", int'(out_right), int'(eb));
        tick(); #1;
        chk("full_out_b_valid", int'(out_valid), 1);
        chk("full_out_b_left", int'(out_left), int'(fa));
        chk("full_out_b_right", int'(out_right), int'(fb));
        tick(); #1;
        exp_cnt += 2;
        chk("full_drained", int'(out_valid), 0);
        chk("full_count", int'(out_count), exp_cnt);

        // Reset with two tuples in flight.
        tick();
        rand_in(); in_valid = 1'b1; out_ready = 1'b0;
        tick();
        rand_in();
        tick();
        in_valid = 1'b0; rst = 1'b1;
        #1; chk("midrst_in_ready", int'(in_ready), 0);
        tick();
        rst = 1'b0; out_ready = 1'b1;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_count", int'(out_count), 0);
        chk("midrst_left", int'(out_left), 0);
        exp_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("midrst_no_ghost", int'(out_valid), 0);
        end
        tick();
        rand_in(); in_valid = 1'b1;
        model(in_l1, in_l2, in_b1, in_b2, ea, eb);
        tick();
        in_valid = 1'b0;
        tick(); #1;
        chk("midrst_new_valid", int'(out_valid), 1);
        chk("midrst_new_left", int'(out_left), int'(ea));
        chk("midrst_new_right", int'(out_right), int'(eb));
        tick();

        // Reset again so the toggled-backpressure stream counts from zero.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        run_stream(10, 0);
        run_stream(300, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
